// File: rtl/alu_trace_pkg.sv
// Shared definitions for the ALUSystem trace recorder.
// Holds the FSM state encodings, the record width and the bit offsets of
// each captured field inside a record, plus a helper that packs a record.
// Record layout (MSB..LSB): {IROut[15:0], Address[7:0], ALUOutFlag[3:0], ALUOut[7:0]}
package alu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_DONE    = 2'b10
  } trace_state_e;

  localparam int REC_W        = 36;
  localparam int REC_ALU_LSB  = 0;
  localparam int REC_FLAG_LSB = 8;
  localparam int REC_ADDR_LSB = 12;
  localparam int REC_IR_LSB   = 20;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [15:0] ir,
    input logic [7:0]  addr,
    input logic [3:0]  flag,
    input logic [7:0]  alu
  );
    logic [REC_W-1:0] r;
    r = '0;
    r[REC_IR_LSB   +: 16] = ir;
    r[REC_ADDR_LSB +: 8]  = addr;
    r[REC_FLAG_LSB +: 4]  = flag;
    r[REC_ALU_LSB  +: 8]  = alu;
    return r;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace buffer storage: DEPTH x REC_W, one write port, one synchronous read port.
// Storage cells are not reset; only the read output register is cleared by rst
// so the popped-record output has a defined value after reset.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-high reset (read register only)
//   we     in  write enable;   waddr/wdata write address/data
//   re     in  read enable;    raddr read address
//   rdata  out registered read data, holds when re is low
module trace_ram
  import alu_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REC_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [REC_W-1:0]  rdata
);

  logic [REC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/alu_system_trace_recorder.sv
// Records ALUSystem results once per clock into a trace buffer and plays them
// back oldest first through a pop-style read port.
// Configuration macro: TRACE_WRAP_EN
//   undefined: capture stops after DEPTH records (stop-on-full)
//   defined:   capture overwrites the oldest record and ends only on Stop
// Ports:
//   Clock, Reset       clock (rising edge) and async active-high reset
//   Start, Stop        arm / end capture (one-cycle pulses)
//   ALUOut, ALUOutFlag, Address, IROut   fields captured into each record
//   RdEn               pop the oldest record (DONE only)
//   RdData, RdValid    popped record and its one-cycle valid
//   Count, Full, Empty records held and occupancy flags
//   Busy               capture in progress
module alu_system_trace_recorder
  import alu_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic [7:0]        ALUOut,
  input  logic [3:0]        ALUOutFlag,
  input  logic [7:0]        Address,
  input  logic [15:0]       IROut,
  input  logic              RdEn,
  output logic [REC_W-1:0]  RdData,
  output logic              RdValid,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic              Busy
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  trace_state_e      state_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              rd_valid_q;
  logic              wr_en, pop;

  // Start in DONE takes priority over a pop on the same edge.
  assign wr_en = (state_q == ST_CAPTURE);
  assign pop   = (state_q == ST_DONE) && RdEn && !Start && (count_q != '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
`ifdef TRACE_WRAP_EN
          // Buffer full: the write overwrites the oldest slot, so the read
          // pointer follows and Count stays saturated.
          if (count_q == DEPTH_C) rd_ptr_q <= rd_ptr_q + PTR_ONE;
          else                    count_q  <= count_q + CNT_ONE;
          if (Stop) state_q <= ST_DONE;
`else
          count_q <= count_q + CNT_ONE;
          // This edge writes record DEPTH: capture ends here.
          if (Stop || (count_q == DEPTH_C - CNT_ONE)) state_q <= ST_DONE;
`endif
        end
        ST_DONE: begin
          if (Start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_CAPTURE;
          end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q  <= count_q - CNT_ONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (Clock),
    .rst   (Reset),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (pack_rec(IROut, Address, ALUOutFlag, ALUOut)),
    .re    (pop),
    .raddr (rd_ptr_q),
    .rdata (RdData)
  );

  assign RdValid = rd_valid_q;
  assign Count   = count_q;
  assign Full    = (count_q == DEPTH_C);
  assign Empty   = (count_q == '0);
  assign Busy    = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_alu_system_trace_recorder.sv
module tb_alu_system_trace_recorder;

  logic        Clock = 1'b0;
  logic        Reset, Start, Stop, RdEn;
  logic [7:0]  ALUOut;
  logic [3:0]  ALUOutFlag;
  logic [7:0]  Address;
  logic [15:0] IROut;
  logic [35:0] RdData;
  logic        RdValid, Full, Empty, Busy;
  logic [4:0]  Count;

  int n_vec = 0;
  int n_err = 0;

  alu_system_trace_recorder #(.DEPTH(16), .ADDR_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
    .ALUOut(ALUOut), .ALUOutFlag(ALUOutFlag), .Address(Address), .IROut(IROut),
    .RdEn(RdEn), .RdData(RdData), .RdValid(RdValid), .Count(Count),
    .Full(Full), .Empty(Empty), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [35:0] rec(input logic [7:0] alu);
    return {16'hA5A5, 8'h10, 4'h5, alu};
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rddata"}, 64'(RdData), 64'h0);
    check_eq({tag, "_rdvalid"}, 64'(RdValid), 64'h0);
    check_eq({tag, "_count"}, 64'(Count), 64'h0);
    check_eq({tag, "_full"}, 64'(Full), 64'h0);
    check_eq({tag, "_empty"}, 64'(Empty), 64'h1);
    check_eq({tag, "_busy"}, 64'(Busy), 64'h0);
  endtask

  // Pop n records, expecting ALUOut values first, first+1, ...
  task automatic pop_expect(input string tag, input int n, input int first);
    RdEn = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq($sformatf("%s_vld%0d", tag, i), 64'(RdValid), 64'h1);
      check_eq($sformatf("%s_data%0d", tag, i), 64'(RdData), 64'(rec(8'(first + i))));
    end
    RdEn = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 0; Stop = 0; RdEn = 0;
    ALUOut = 0; ALUOutFlag = 4'h5; Address = 8'h10; IROut = 16'hA5A5;
    #12;
    check_reset_vals("por");
    Reset = 1'b0;
    tick();

    // Basic 3-record capture, Stop on the third.
    Start = 1; tick(); Start = 0;
    check_eq("t2_busy", 64'(Busy), 64'h1);
    ALUOut = 8'h01; tick();
    ALUOut = 8'h02; tick();
    ALUOut = 8'h03; Stop = 1; tick(); Stop = 0;
    check_eq("t2_count", 64'(Count), 64'd3);
    check_eq("t2_busy_done", 64'(Busy), 64'h0);
    pop_expect("t2", 3, 1);
    check_eq("t2_empty", 64'(Empty), 64'h1);

    // RdEn with empty buffer: no pop, RdData holds last record.
    RdEn = 1; tick(); RdEn = 0;
    check_eq("t5_vld_empty", 64'(RdValid), 64'h0);
    check_eq("t5_hold", 64'(RdData), 64'(rec(8'h03)));
    check_eq("t5_count", 64'(Count), 64'h0);

    // RdEn during CAPTURE is ignored; capture 4 records.
    Start = 1; tick(); Start = 0;
    RdEn = 1;
    for (int i = 0; i < 4; i++) begin
      ALUOut = 8'(8'h40 + i);
      if (i == 3) Stop = 1;
      tick();
      check_eq($sformatf("t5_cap_vld%0d", i), 64'(RdValid), 64'h0);
    end
    Stop = 0; RdEn = 0;
    check_eq("t5_cap_count", 64'(Count), 64'd4);
    check_eq("t5_cap_hold", 64'(RdData), 64'(rec(8'h03)));

    // Start and RdEn together in DONE: restart wins.
    Start = 1; RdEn = 1; ALUOut = 8'hEE; tick(); Start = 0; RdEn = 0;
    check_eq("t6_count", 64'(Count), 64'h0);
    check_eq("t6_busy", 64'(Busy), 64'h1);
    check_eq("t6_vld", 64'(RdValid), 64'h0);

    // Full capture: ALUOut = 0..20.
    for (int i = 0; i <= 20; i++) begin
      ALUOut = 8'(i);
`ifdef TRACE_WRAP_EN
      if (i == 20) Stop = 1;
`endif
      tick();
    end
    Stop = 0;
    check_eq("t3_full", 64'(Full), 64'h1);
    check_eq("t3_count", 64'(Count), 64'd16);
    check_eq("t3_busy", 64'(Busy), 64'h0);
`ifdef TRACE_WRAP_EN
    pop_expect("t4", 16, 5);
`else
    pop_expect("t3", 16, 0);
`endif
    check_eq("t3_empty", 64'(Empty), 64'h1);

    // Reset mid-capture.
    Start = 1; tick(); Start = 0;
    ALUOut = 8'h77; tick(); tick();
    check_eq("t1_pre_count", 64'(Count), 64'd2);
    #2 Reset = 1'b1; #1;
    check_reset_vals("t1_mid");
    tick();
    check_reset_vals("t1_hold");
    Reset = 1'b0;
    tick();
    check_eq("t1_idle_busy", 64'(Busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
